// File: rtl/psr_flag_unit.sv
// rtl/psr_flag_unit.sv - N/Z/C/V status register with EX->ID flag forwarding or interlock
// Derives flags from the EX-stage ALU result and commits them into the status register.

module psr_flag_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             S_in,
  input  logic             upd_cv,
  input  logic             psr_we,
  input  logic [3:0]       psr_wdata,
  input  logic             stall,
  input  logic             flush,
  input  logic             ID_uses_cond,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             N_fwd,
  output logic             Z_fwd,
  output logic             C_fwd,
  output logic             V_fwd,
  output logic             flag_stall,
  output logic             flag_busy
);

  logic [3:0] flags_q, flags_d;
  logic [3:0] alu_flags;
  logic [3:0] ex_flags;
  logic [3:0] fwd_flags;
  logic       upd;

  // Logical ops (upd_cv=0) carry the committed C/V through unchanged.
  always_comb begin
    alu_flags[3] = alu_result[WIDTH-1];
    alu_flags[2] = (alu_result == '0);
    alu_flags[1] = upd_cv ? alu_carry : flags_q[1];
    alu_flags[0] = upd_cv ? alu_ovf   : flags_q[0];
  end

  assign ex_flags = psr_we ? psr_wdata : alu_flags;

  // Gating with reset keeps busy/stall/forwarding quiet while the register is cleared.
  assign upd       = (S_in | psr_we) & ~flush & ~reset;
  assign flag_busy = upd;

  always_comb begin
    flags_d = flags_q;
    if (upd && !stall) begin
      flags_d = ex_flags;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  always_comb begin
    fwd_flags  = flags_q;
    flag_stall = 1'b0;
    if (FWD_EN) begin
      if (upd) begin
        fwd_flags = ex_flags;
      end
    end else begin
      // A held setter is re-presented next cycle, so the interlock waits for it to move.
      flag_stall = upd & ID_uses_cond & ~stall;
    end
  end

  assign {N, Z, C, V}                 = flags_q;
  assign {N_fwd, Z_fwd, C_fwd, V_fwd} = fwd_flags;

endmodule

// File: tb/tb_psr_flag_unit.sv
// tb/tb_psr_flag_unit.sv - directed self-checking bench for psr_flag_unit
// Two instances share stimulus: u_fwd forwards flags, u_stl interlocks instead.

module tb_psr_flag_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result;
  logic        alu_carry, alu_ovf, S_in, upd_cv, psr_we;
  logic [3:0]  psr_wdata;
  logic        stall, flush, ID_uses_cond;

  logic fN, fZ, fC, fV, fNf, fZf, fCf, fVf, f_stall, f_busy;
  logic sN, sZ, sC, sV, sNf, sZf, sCf, sVf, s_stall, s_busy;

  wire [3:0] f_nzcv = {fN, fZ, fC, fV};
  wire [3:0] f_fwd  = {fNf, fZf, fCf, fVf};
  wire [3:0] s_nzcv = {sN, sZ, sC, sV};
  wire [3:0] s_fwd  = {sNf, sZf, sCf, sVf};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psr_flag_unit #(.WIDTH(32), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .reset(reset), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_ovf(alu_ovf), .S_in(S_in), .upd_cv(upd_cv), .psr_we(psr_we),
    .psr_wdata(psr_wdata), .stall(stall), .flush(flush), .ID_uses_cond(ID_uses_cond),
    .N(fN), .Z(fZ), .C(fC), .V(fV), .N_fwd(fNf), .Z_fwd(fZf), .C_fwd(fCf), .V_fwd(fVf),
    .flag_stall(f_stall), .flag_busy(f_busy)
  );

  psr_flag_unit #(.WIDTH(32), .FWD_EN(1'b0)) u_stl (
    .clk(clk), .reset(reset), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_ovf(alu_ovf), .S_in(S_in), .upd_cv(upd_cv), .psr_we(psr_we),
    .psr_wdata(psr_wdata), .stall(stall), .flush(flush), .ID_uses_cond(ID_uses_cond),
    .N(sN), .Z(sZ), .C(sC), .V(sV), .N_fwd(sNf), .Z_fwd(sZf), .C_fwd(sCf), .V_fwd(sVf),
    .flag_stall(s_stall), .flag_busy(s_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_result = 32'h1; alu_carry = 1'b0; alu_ovf = 1'b0;
    S_in = 1'b0; upd_cv = 1'b1; psr_we = 1'b0; psr_wdata = 4'b0000;
    stall = 1'b0; flush = 1'b0; ID_uses_cond = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; S_in = 1'b1; alu_result = 32'h0; ID_uses_cond = 1'b1;
    #1;
    checks++; if (f_nzcv !== 4'b0000 || s_nzcv !== 4'b0000) begin errors++;
      $display("FAIL reset_nzcv: got %b/%b want 0000", f_nzcv, s_nzcv); end
    checks++; if (s_stall !== 1'b0 || f_busy !== 1'b0 || f_fwd !== 4'b0000) begin errors++;
      $display("FAIL reset_outs: stall=%b busy=%b fwd=%b want 0 0 0000", s_stall, f_busy, f_fwd); end
    step();
    reset = 1'b0;
    step();
    checks++; if (f_nzcv !== 4'b0100 || s_nzcv !== 4'b0100) begin errors++;
      $display("FAIL reset_first_commit: got %b/%b want 0100", f_nzcv, s_nzcv); end
  endtask

  task automatic test_negative();
    idle();
    alu_result = 32'h8000_0000; alu_carry = 1'b1; alu_ovf = 1'b1; S_in = 1'b1;
    #1;
    checks++; if (f_fwd !== 4'b1011 || f_nzcv !== 4'b0100) begin errors++;
      $display("FAIL neg_fwd: fwd=%b nzcv=%b want 1011 0100", f_fwd, f_nzcv); end
    step();
    idle();
    checks++; if (f_nzcv !== 4'b1011 || s_nzcv !== 4'b1011) begin errors++;
      $display("FAIL neg_commit: got %b/%b want 1011", f_nzcv, s_nzcv); end
  endtask

  task automatic test_hold_cv();
    idle(); psr_we = 1'b1; psr_wdata = 4'b0011;
    step();
    idle(); S_in = 1'b1; upd_cv = 1'b0; alu_result = 32'h0; alu_carry = 1'b0; alu_ovf = 1'b0;
    step();
    idle();
    checks++; if (f_nzcv !== 4'b0111) begin errors++;
      $display("FAIL hold_cv: got %b want 0111", f_nzcv); end
  endtask

  task automatic test_psr_we();
    idle(); psr_we = 1'b1; psr_wdata = 4'b0110; S_in = 1'b1;
    alu_result = 32'hFFFF_FFFF; alu_carry = 1'b1; alu_ovf = 1'b1;
    #1;
    checks++; if (f_fwd !== 4'b0110 || f_busy !== 1'b1) begin errors++;
      $display("FAIL psr_we_fwd: fwd=%b busy=%b want 0110 1", f_fwd, f_busy); end
    step();
    checks++; if (f_nzcv !== 4'b0110) begin errors++;
      $display("FAIL psr_we_commit: got %b want 0110", f_nzcv); end
    psr_wdata = 4'b1001; flush = 1'b1; ID_uses_cond = 1'b1;
    #1;
    checks++; if (f_busy !== 1'b0 || s_stall !== 1'b0 || f_fwd !== 4'b0110) begin errors++;
      $display("FAIL flush_comb: busy=%b stall=%b fwd=%b want 0 0 0110", f_busy, s_stall, f_fwd); end
    step();
    idle();
    checks++; if (f_nzcv !== 4'b0110 || s_nzcv !== 4'b0110) begin errors++;
      $display("FAIL flush_hold: got %b/%b want 0110", f_nzcv, s_nzcv); end
  endtask

  task automatic test_stall();
    idle(); psr_we = 1'b1; psr_wdata = 4'b1000;
    step();
    idle(); stall = 1'b1; S_in = 1'b1; alu_result = 32'h0; ID_uses_cond = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_stall !== 1'b0) begin errors++;
        $display("FAIL stall_no_interlock: cycle %0d got %b want 0", i, s_stall); end
      step();
      checks++; if (f_nzcv !== 4'b1000) begin errors++;
        $display("FAIL stall_hold: cycle %0d got %b want 1000", i, f_nzcv); end
    end
    stall = 1'b0; ID_uses_cond = 1'b0;
    step();
    idle();
    checks++; if (f_nzcv !== 4'b0100) begin errors++;
      $display("FAIL stall_release: got %b want 0100", f_nzcv); end
  endtask

  task automatic test_interlock();
    idle(); S_in = 1'b1; alu_result = 32'h1; alu_carry = 1'b1; ID_uses_cond = 1'b1;
    #1;
    checks++; if (s_stall !== 1'b1 || s_fwd !== 4'b0100) begin errors++;
      $display("FAIL interlock_on: stall=%b fwd=%b want 1 0100", s_stall, s_fwd); end
    checks++; if (f_stall !== 1'b0 || f_fwd !== 4'b0010) begin errors++;
      $display("FAIL fwd_no_stall: stall=%b fwd=%b want 0 0010", f_stall, f_fwd); end
    step();
    S_in = 1'b0;
    #1;
    checks++; if (s_stall !== 1'b0 || s_fwd !== 4'b0010) begin errors++;
      $display("FAIL interlock_off: stall=%b fwd=%b want 0 0010", s_stall, s_fwd); end
    idle();
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    idle(); ID_uses_cond = 1'b1; S_in = 1'b1; upd_cv = 1'b0; alu_result = 32'hFFFF_FFFF;
    #1;
    if (s_stall === 1'b1) stalls++;
    step();
    upd_cv = 1'b1; alu_result = 32'h0; alu_carry = 1'b0; alu_ovf = 1'b1;
    #1;
    if (s_stall === 1'b1) stalls++;
    checks++; if (s_fwd !== 4'b1010) begin errors++;
      $display("FAIL b2b_mid: fwd=%b want 1010", s_fwd); end
    step();
    S_in = 1'b0;
    #1;
    if (s_stall === 1'b1) stalls++;
    checks++; if (stalls != 2) begin errors++;
      $display("FAIL b2b_stalls: got %0d want 2", stalls); end
    checks++; if (s_nzcv !== 4'b0101) begin errors++;
      $display("FAIL b2b_commit: got %b want 0101", s_nzcv); end
    idle();
  endtask

  task automatic test_reset_mid_update();
    idle(); S_in = 1'b1; alu_result = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (f_nzcv !== 4'b0000 || f_fwd !== 4'b0000) begin errors++;
      $display("FAIL reset_async: nzcv=%b fwd=%b want 0000 0000", f_nzcv, f_fwd); end
    step();
    reset = 1'b0; S_in = 1'b0;
    step();
    checks++; if (f_nzcv !== 4'b0000 || s_nzcv !== 4'b0000) begin errors++;
      $display("FAIL reset_discard: got %b/%b want 0000", f_nzcv, s_nzcv); end
  endtask

  initial begin
    test_reset();
    test_negative();
    test_hold_cv();
    test_psr_we();
    test_stall();
    test_interlock();
    test_back_to_back();
    test_reset_mid_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
